// File: rtl/seven_seg_scanner_n_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner_n_pkg
//   Shared constants and helpers for the N-digit seven-segment anode scanner.
//   - DEF_* : default parameter values for the scanner and its prescaler
//   - MAX_DIGITS / ANODE_OFF : widest supported anode bus and its "all off"
//     value (active-low, so all ones)
//   - digit_w() : width of an index/counter covering 0..n-1, never below 1
// -----------------------------------------------------------------------------
package seven_seg_scanner_n_pkg;

    localparam int unsigned DEF_DIGITS    = 4;
    localparam int unsigned DEF_PRESCALE  = 100000;
    localparam int unsigned DEF_GUARD     = 2;
    localparam int unsigned DEF_DUTY_BITS = 3;

    localparam int unsigned MAX_DIGITS = 16;

    // Active-low anodes: all ones means every digit is dark.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Width needed to hold values 0..n-1; a single-entry range still gets
    // one bit so ports and registers never collapse to zero width.
    function automatic int unsigned digit_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_n_scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
//   Dwell counter for the anode scanner. Counts 0..PRESCALE-1 while enabled
//   and holds its value while disabled.
//   Ports:
//     clock  - system clock, rising edge
//     reset  - asynchronous, active-low
//     enable - 1 = count, 0 = hold
//     count  - current dwell position (pre_cnt)
//     wrap   - combinational strobe: enabled and count is at PRESCALE-1,
//              i.e. the next edge ends the current dwell
// -----------------------------------------------------------------------------
module scan_prescaler
    import seven_seg_scanner_n_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    localparam int unsigned CNT_W   = digit_w(PRESCALE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    always_comb begin
        wrap = enable && (count == LAST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (enable) begin
            if (wrap) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scanner_n.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner_n
//   Multiplexes DIGITS common-anode seven-segment digits from the system
//   clock. Each digit is selected for PRESCALE cycles; the first GUARD cycles
//   of every dwell keep all anodes dark to avoid ghosting, and a free-running
//   PWM counter gates the remaining window against the brightness level.
//   Ports:
//     clock      - system clock, rising edge
//     reset      - asynchronous, active-low
//     enable     - 1 = scan; 0 = freeze counters, anodes dark
//     blank_mask - bit i = 1 keeps digit i dark
//     brightness - PWM on-level; all ones = fully on outside the guard
//     anode      - active-low anode drive, registered, at most one bit low
//     digit_sel  - index of the digit being scanned, registered
//     scan_tick  - one-cycle pulse in the cycle digit_sel has just advanced
// -----------------------------------------------------------------------------
module seven_seg_scanner_n
    import seven_seg_scanner_n_pkg::*;
#(
    parameter int unsigned DIGITS    = DEF_DIGITS,
    parameter int unsigned PRESCALE  = DEF_PRESCALE,
    parameter int unsigned GUARD     = DEF_GUARD,
    parameter int unsigned DUTY_BITS = DEF_DUTY_BITS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [DIGITS-1:0]            blank_mask,
    input  logic [DUTY_BITS-1:0]         brightness,
    output logic [DIGITS-1:0]            anode,
    output logic [digit_w(DIGITS)-1:0]   digit_sel,
    output logic                         scan_tick
);

    localparam int unsigned DIGIT_W = digit_w(DIGITS);
    localparam int unsigned PRE_W   = digit_w(PRESCALE);

    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  ALL_OFF    = ANODE_OFF[DIGITS-1:0];

    if (PRESCALE < 2 || GUARD >= PRESCALE || DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_param_check
        $error("seven_seg_scanner_n: illegal DIGITS/PRESCALE/GUARD combination");
    end

    logic [PRE_W-1:0]     pre_cnt;
    logic                 pre_wrap;
    logic [DIGIT_W-1:0]   digit;
    logic [DUTY_BITS-1:0] pwm_cnt;
    logic                 past_guard;
    logic [DIGITS-1:0]    anode_next;

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .count  (pre_cnt),
        .wrap   (pre_wrap)
    );

    // With no guard interval every dwell position is eligible; keeping this
    // as a separate branch avoids a constant "unsigned >= 0" compare.
    if (GUARD == 0) begin : g_no_guard
        always_comb begin
            past_guard = 1'b1;
        end
    end else begin : g_guard
        always_comb begin
            past_guard = (pre_cnt >= PRE_W'(GUARD));
        end
    end

    // Decoded from the current registered state, so the anode that turns on
    // always trails digit_sel by one cycle and the segment mux has settled.
    always_comb begin
        anode_next = ALL_OFF;
        if (enable && !blank_mask[digit] && past_guard && (pwm_cnt <= brightness)) begin
            anode_next[digit] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit     <= '0;
            pwm_cnt   <= '0;
            anode     <= ALL_OFF;
            scan_tick <= 1'b0;
        end else begin
            anode     <= anode_next;
            scan_tick <= pre_wrap;
            if (enable) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (pre_wrap) begin
                    if (digit == LAST_DIGIT) begin
                        digit <= '0;
                    end else begin
                        digit <= digit + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        digit_sel = digit;
    end

endmodule

// File: tb/tb_seven_seg_scanner_n.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner_n
//   Two scanner instances (4 and 5 digits, PRESCALE=4, GUARD=1, DUTY_BITS=2)
//   driven by directed stimulus and checked every cycle against an arithmetic
//   model based on the number of enabled cycles since reset.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner_n;

    localparam int unsigned P  = 4;
    localparam int unsigned G  = 1;
    localparam int unsigned DB = 2;

    logic       clock;
    logic       reset;

    logic       en4;
    logic [3:0] blank4;
    logic [1:0] bright4;
    logic [3:0] anode4;
    logic [1:0] dsel4;
    logic       tick4;

    logic       en5;
    logic [4:0] blank5;
    logic [1:0] bright5;
    logic [4:0] anode5;
    logic [2:0] dsel5;
    logic       tick5;

    int n_cmp;
    int n_fail;

    seven_seg_scanner_n #(
        .DIGITS    (4),
        .PRESCALE  (P),
        .GUARD     (G),
        .DUTY_BITS (DB)
    ) dut4 (
        .clock      (clock),
        .reset      (reset),
        .enable     (en4),
        .blank_mask (blank4),
        .brightness (bright4),
        .anode      (anode4),
        .digit_sel  (dsel4),
        .scan_tick  (tick4)
    );

    seven_seg_scanner_n #(
        .DIGITS    (5),
        .PRESCALE  (P),
        .GUARD     (G),
        .DUTY_BITS (DB)
    ) dut5 (
        .clock      (clock),
        .reset      (reset),
        .enable     (en5),
        .blank_mask (blank5),
        .brightness (bright5),
        .anode      (anode5),
        .digit_sel  (dsel5),
        .scan_tick  (tick5)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Anode pattern for a scanner that has been enabled for t cycles since
    // reset: dwell position, digit and PWM phase all follow from t directly.
    function automatic logic [15:0] model_anode(input int unsigned t, input int unsigned nd,
                                                input logic [15:0] blank, input int unsigned bright);
        int unsigned pre;
        int unsigned d;
        int unsigned pwm;
        pre = t % P;
        d   = (t / P) % nd;
        pwm = t % (1 << DB);
        model_anode = '1;
        if (!blank[d] && pre >= G && pwm <= bright) begin
            model_anode[d] = 1'b0;
        end
    endfunction

    // ---------------- per-cycle model compare ----------------
    int unsigned t4;
    int unsigned t5;
    logic [3:0]  ea4;
    logic [1:0]  ed4;
    logic        es4;
    logic [4:0]  ea5;
    logic [2:0]  ed5;
    logic        es5;

    always @(posedge clock) begin
        if (!reset) begin
            t4  = 0;
            ea4 = '1;
            es4 = 1'b0;
        end else if (en4) begin
            ea4 = 4'(model_anode(t4, 4, 16'(blank4), 32'(bright4)));
            es4 = ((t4 % P) == P - 1);
            t4++;
        end else begin
            ea4 = '1;
            es4 = 1'b0;
        end
        ed4 = 2'((t4 / P) % 4);
        #1;
        check("model_anode4", 32'(anode4), 32'(ea4));
        check("model_dsel4", 32'(dsel4), 32'(ed4));
        check("model_tick4", 32'(tick4), 32'(es4));
    end

    always @(posedge clock) begin
        if (!reset) begin
            t5  = 0;
            ea5 = '1;
            es5 = 1'b0;
        end else if (en5) begin
            ea5 = 5'(model_anode(t5, 5, 16'(blank5), 32'(bright5)));
            es5 = ((t5 % P) == P - 1);
            t5++;
        end else begin
            ea5 = '1;
            es5 = 1'b0;
        end
        ed5 = 3'((t5 / P) % 5);
        #1;
        check("model_anode5", 32'(anode5), 32'(ea5));
        check("model_dsel5", 32'(dsel5), 32'(ed5));
        check("model_tick5", 32'(tick5), 32'(es5));
    end

    // Random blank/brightness for the 5-digit instance.
    initial begin
        en5     = 1'b1;
        blank5  = '0;
        bright5 = 2'd3;
        forever begin
            @(negedge clock);
            blank5  = 5'($urandom);
            bright5 = 2'($urandom);
        end
    end

    // Global bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    // ---------------- directed scenarios on the 4-digit instance ----------------
    logic [3:0] seq_lit [16];
    logic [3:0] tick_lit;

    initial begin
        int          cnt;
        int          n;
        logic        flag_a;
        logic        flag_b;
        int          ticks;
        int          bad;
        logic [2:0]  prev;

        seq_lit = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                    4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

        n_cmp   = 0;
        n_fail  = 0;
        reset   = 1'b0;
        en4     = 1'b1;
        bright4 = 2'd3;
        blank4  = 4'b0000;

        // 1. reset then run
        repeat (3) @(negedge clock);
        check("reset_anode", 32'(anode4), 32'h0000_000F);
        check("reset_dsel", 32'(dsel4), 32'd0);
        check("reset_tick", 32'(tick4), 32'd0);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            check("run_anode_seq", 32'(anode4), 32'(seq_lit[k-1]));
            tick_lit = ((k % 4) == 0) ? 4'd1 : 4'd0;
            check("run_tick_seq", 32'(tick4), 32'(tick_lit));
        end

        // 2. blanking digit 2
        blank4 = 4'b0100;
        flag_a = 1'b0;
        flag_b = 1'b0;
        repeat (16) begin
            @(negedge clock);
            if (anode4 == 4'hB) flag_a = 1'b1;
            if (dsel4 == 2'd2)  flag_b = 1'b1;
        end
        check("blank_never_1011", 32'(flag_a), 32'd0);
        check("blank_visits_2", 32'(flag_b), 32'd1);
        blank4 = 4'b0000;

        // 3. brightness: lit cycles over four whole dwells
        bright4 = 2'd1;
        cnt = 0;
        repeat (16) begin
            @(negedge clock);
            if (anode4 != 4'hF) cnt++;
        end
        check("bright1_on_cycles", 32'(cnt), 32'd4);
        bright4 = 2'd3;
        cnt = 0;
        repeat (16) begin
            @(negedge clock);
            if (anode4 != 4'hF) cnt++;
        end
        check("bright3_on_cycles", 32'(cnt), 32'd12);

        // 4. enable freeze at digit 2 (first cycle of its dwell)
        n = 0;
        while (dsel4 == 2'd2 && n < 64) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (dsel4 != 2'd2 && n < 64) begin
            @(negedge clock);
            n++;
        end
        check("freeze_reach_digit2", 32'(dsel4), 32'd2);
        en4 = 1'b0;
        @(negedge clock);
        check("freeze_anode_off", 32'(anode4), 32'h0000_000F);
        check("freeze_tick_low", 32'(tick4), 32'd0);
        flag_a = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (dsel4 != 2'd2 || anode4 != 4'hF || tick4 != 1'b0) flag_a = 1'b0;
        end
        check("freeze_hold", 32'(flag_a), 32'd1);
        en4 = 1'b1;
        n = 0;
        while (dsel4 != 2'd3 && n < 64) begin
            @(negedge clock);
            n++;
        end
        check("resume_cycles_to_3", 32'(n), 32'd4);

        // 5. asynchronous reset mid-scan
        n = 0;
        while (anode4 != 4'hD && n < 64) begin
            @(negedge clock);
            n++;
        end
        check("async_find_1101", 32'(anode4), 32'h0000_000D);
        #2 reset = 1'b0;
        #1;
        check("async_anode", 32'(anode4), 32'h0000_000F);
        check("async_dsel", 32'(dsel4), 32'd0);
        check("async_tick", 32'(tick4), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("restart_guard", 32'(anode4), 32'h0000_000F);
        @(negedge clock);
        check("restart_anode", 32'(anode4), 32'h0000_000E);
        check("restart_dsel", 32'(dsel4), 32'd0);

        // 6. five-digit wrap, one-hot invariant, tick rate
        ticks  = 0;
        bad    = 0;
        flag_a = 1'b0;
        prev   = dsel5;
        repeat (1000) begin
            @(negedge clock);
            if (tick5) ticks++;
            if (prev == 3'd4 && dsel5 == 3'd0) flag_a = 1'b1;
            prev = dsel5;
            if (!(anode5 == 5'h1F || $onehot(~anode5))) bad++;
        end
        check("wrap5_4_to_0", 32'(flag_a), 32'd1);
        check("onehot5_violations", 32'(bad), 32'd0);
        check("tick5_count", 32'(ticks), 32'd250);

        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner_n.md
Name: seven_seg_scanner_n

Overview:
Parametrised successor to the fixed 4-digit anode scanner. Multiplexes DIGITS common-anode seven-segment digits from the system clock using an internal prescaler; no external divided clock is needed. Adds per-digit blanking, PWM brightness and an anti-ghosting guard interval. Outputs the active digit index so the segment/data mux can select digit data ahead of the anode.

Parameters:
DIGITS, 4, number of digits scanned (1..16)
PRESCALE, 100000, clock cycles each digit is selected (dwell); must be >= 2 and > GUARD
GUARD, 2, cycles at start of each dwell with all anodes off (0 disables)
DUTY_BITS, 3, width of brightness control and PWM counter

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
enable  in  1  1 = scan; 0 = freeze counters, all anodes off
blank_mask  in  DIGITS  bit i = 1 forces digit i off
brightness  in  DUTY_BITS  on-time level; all-ones = fully on
anode  out  DIGITS  active-low anode drive, registered
digit_sel  out  max(1,clog2(DIGITS))  index of current digit, registered
scan_tick  out  1  one-cycle pulse when digit_sel advances

Behaviour:
- State: pre_cnt (0..PRESCALE-1), digit (0..DIGITS-1), pwm_cnt (DUTY_BITS, wraps), anode reg, scan_tick reg.
- Reset (async, reset=0): pre_cnt=0, digit=0, pwm_cnt=0, anode=all ones, digit_sel=0, scan_tick=0. Reset mid-scan takes effect immediately, with no waiting for a clock edge. After release, scanning restarts at digit 0.
- enable=1, each clock:
  - pwm_cnt increments and wraps.
  - pre_cnt increments. At PRESCALE-1 it wraps to 0, digit advances (DIGITS-1 wraps to 0) and scan_tick=1 on the following cycle. Otherwise scan_tick=0.
- Anode update each clock: anode <= all ones, except that bit[digit] is driven 0 when all of the following hold:
  - enable=1
  - blank_mask[digit]=0
  - pre_cnt >= GUARD
  - pwm_cnt <= brightness
- anode is computed from current registered state, so it lags digit_sel by exactly 1 cycle. Segment data selected by digit_sel is therefore settled before the anode turns on.
- At most one anode bit is 0 at any time (one-hot-low or all ones). This is an invariant.
- blank_mask/brightness changes take effect on the next anode update (1-cycle latency). No other synchronisation is applied; inputs must be in the clock domain.
- enable=0:
  - pre_cnt, digit and pwm_cnt hold.
  - anode goes to all ones and scan_tick goes to 0 on the next edge.
  - Re-asserting enable resumes from the held state.
- DIGITS=1: digit_sel stays 0; scan_tick still pulses every PRESCALE cycles.
- brightness all-ones: full duty within the non-guard window. brightness=0: on for 1 of every 2^DUTY_BITS cycles.
- Elaboration check: fail if PRESCALE<2, GUARD>=PRESCALE, DIGITS<1 or DIGITS>16.

Decomposition:
- Shared package holds:
  - DIGIT_W = max(1,clog2(DIGITS)) helper function
  - default DIGITS/PRESCALE/GUARD/DUTY_BITS constants
  - ANODE_OFF (all ones) constant
- Sub-module scan_prescaler (clock, reset, enable, PRESCALE parameter) owns pre_cnt and emits a wrap strobe plus count value. The top level owns digit, pwm_cnt, the anode decode and the output registers.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=4, GUARD=1, DUTY_BITS=2 unless noted.
1. Reset then run: reset=0, then released with enable=1, brightness=3, blank_mask=0000.
   - While reset=0: anode=1111, digit_sel=0, scan_tick=0.
   - After release: each digit's anode is low for 3 of 4 cycles, 1 cycle after digit_sel changes.
   - Anode order is 1110 -> 1101 -> 1011 -> 0111 -> 1110.
   - scan_tick pulses every 4 cycles.
2. Blanking: blank_mask=0100 -> anode never equals 1011; the other digits scan unchanged; digit_sel still visits index 2.
3. Brightness: brightness=1 -> each digit is active only at pre_cnt=1, so 1 cycle of 4 per dwell. With brightness=3 the same digit is active for 3 cycles.
4. Enable freeze: drop enable while digit_sel=2.
   - Next cycle: anode=1111 and scan_tick=0.
   - Counters hold for 10 cycles.
   - On re-enable, digit_sel=2 continues and advances to 3 at the expected count.
5. Async reset mid-scan: assert reset between clock edges while anode=1101.
   - anode=1111 and digit_sel=0 immediately, before the next edge.
   - After release, scanning starts at 1110.
6. Wrap and one-hot: DIGITS=5, run 1000 cycles with random blank_mask/brightness.
   - digit_sel wraps 4->0.
   - anode is always all ones or exactly one zero.
   - scan_tick count = floor(cycles/PRESCALE).
